tmds_encoder: RTL and testbench
===============================

Name: tmds_encoder

Overview:
- Downstream stage of the video controller.
- Takes the registered pixel-clock outputs (rgb, hsync, vsync, blank) and produces three 10-bit TMDS symbols per pixel for the DVI/HDMI serialiser.
- Implements DVI 1.0 8b/10b transition-minimised, DC-balanced encoding during active video, and control tokens during blanking.
- Fully pipelined: one symbol triple per clk_pixel.

Parameters:
- SYNC_INVERT, 0: when 1, hsync/vsync are inverted before encoding. The controller drives active-low syncs; 0 passes the raw levels onto C0/C1.

Ports:
- clk_pixel  input  1  pixel clock; all logic on its rising edge.
- nreset  input  1  synchronous, active-low reset, sampled on the clk_pixel rising edge.
- rgb  input  24  pixel colour {red[23:16], grn[15:8], blu[7:0]}.
- hsync  input  1  horizontal sync level from the video controller.
- vsync  input  1  vertical sync level from the video controller.
- blank  input  1  1 = outside the visible area; control period.
- tmds_red  output  10  channel 2 symbol, bit 0 transmitted first.
- tmds_grn  output  10  channel 1 symbol.
- tmds_blu  output  10  channel 0 symbol.

Behaviour:
- Reset (nreset=0 at a clock edge):
  - All pipeline registers clear.
  - Disparity counters clear to 0.
  - All three outputs = 10'b1101010100 (C1C0=00 token).
  - No X on any output from the first edge after reset.
  - Reset mid-frame takes effect on that edge, with no partial symbol emitted.
- Latency is exactly 2 clk_pixel cycles:
  - Stage 0 registers the inputs.
  - Stage 1 computes q_m[8:0] and the popcounts; blank and syncs are delayed alongside.
  - Stage 2 registers the final symbol and updates the disparity counter.
- Control period (delayed blank=1):
  - Channel 0 control bits are {C1,C0} = {vsync, hsync} after SYNC_INVERT. Channels 1 and 2 use C=00.
  - Tokens: 00 -> 1101010100; 01 -> 0010101011; 10 -> 0101010100; 11 -> 1010101011.
  - The disparity counter of every channel is forced to 0.
- Active period, per channel, data D[7:0]:
  - N1(D) = number of ones in D.
  - Use XNOR if N1(D)>4 or (N1(D)==4 and D[0]==0); otherwise XOR.
  - q_m[0]=D[0]; q_m[i] = q_m[i-1] XOR/XNOR D[i]; q_m[8] = 1 for XOR, 0 for XNOR.
- Output and disparity update, with cnt a signed 5-bit counter (range -8..+8 covers every reachable value):
  - If cnt==0 or N1(q_m[7:0])==N0(q_m[7:0]):
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + N0 - N1.
  - Else:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += N1 - N0 - 2*~q_m[8].
- Boundaries:
  - The first active pixel after blanking always starts from cnt=0.
  - blank toggling every cycle is legal; each cycle is encoded independently per the rules above.
  - The three channels are fully independent; only channel 0 carries syncs.

Decomposition:
- Shared package video_pkg holds:
  - TMDS control token constants (TMDS_CTL_00..TMDS_CTL_11).
  - Symbol width 10.
  - Channel index constants.
- One sub-module, tmds_channel:
  - Ports: clk_pixel, nreset, 8-bit data, 2-bit ctl, de; 10-bit symbol out.
  - Holds the 2-stage pipeline and disparity counter.
- tmds_encoder does the input register, SYNC_INVERT and three tmds_channel instances.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with random inputs -> all outputs 10'h354 (1101010100) throughout and on the first cycle after release until real data arrives 2 cycles later.
- Control tokens: blank=1, SYNC_INVERT=0, {vsync,hsync} = 00/01/10/11 -> tmds_blu = 0x354/0x0AB/0x154/0x2AB two cycles later. tmds_grn and tmds_red stay 0x354.
- Blue data 0x00 sequence: blank=1 then three pixels rgb=0 with blank=0 -> tmds_blu = 0x100, 0x3FF, 0x100 (cnt 0 -> -8 -> +2 -> -6).
- Data 0xFF from cnt=0: one active pixel rgb=24'hFFFFFF after blanking -> each channel outputs 0x200.
- Latency/alignment: one-cycle active pulse between blanking -> exactly one data symbol appears, aligned on all three channels 2 cycles after input. Control tokens appear on both sides of it.
- Golden-model sweep: 10k random rgb with random blank runs, checked against a behavioural DVI encoder. Decode of each symbol recovers D, and running disparity never exceeds ±8.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: TMDS symbol width, control tokens, channel indices
// and the small helpers used by the TMDS encoder.
package video_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] TMDS_CTL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TMDS_CTL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TMDS_CTL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TMDS_CTL_11 = 10'b1010101011;

  localparam int CH_BLU = 0;
  localparam int CH_GRN = 1;
  localparam int CH_RED = 2;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Control bits are {C1, C0}.
  function automatic logic [SYM_W-1:0] tmds_ctl_token(input logic [1:0] c);
    logic [SYM_W-1:0] t;
    case (c)
      2'b00:   t = TMDS_CTL_00;
      2'b01:   t = TMDS_CTL_01;
      2'b10:   t = TMDS_CTL_10;
      default: t = TMDS_CTL_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: q_m transition-minimising stage followed by the
// DC-balancing output stage with its running disparity counter.
module tmds_channel
  import video_pkg::*;
(
  input  logic             clk_pixel,
  input  logic             nreset,
  input  logic [7:0]       data,
  input  logic [1:0]       ctl,
  input  logic             de,
  output logic [SYM_W-1:0] symbol
);

  logic [3:0]        n1_data;
  logic              use_xnor;
  logic [8:0]        qm;
  logic [8:0]        qm_s1;
  logic [3:0]        n1_s1;
  logic              de_s1;
  logic [1:0]        ctl_s1;
  logic signed [4:0] cnt;
  logic signed [5:0] cnt_w;
  logic signed [5:0] diff;
  logic signed [5:0] cnt_next;
  logic [SYM_W-1:0]  sym_next;

  always_comb begin
    n1_data  = popcount8(data);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
    qm       = '0;
    qm[0]    = data[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ data[i]) : (qm[i-1] ^ data[i]);
    qm[8] = ~use_xnor;
  end

  always_ff @(posedge clk_pixel) begin
    if (!nreset) begin
      qm_s1  <= '0;
      n1_s1  <= '0;
      de_s1  <= 1'b0;
      ctl_s1 <= '0;
    end else begin
      qm_s1  <= qm;
      n1_s1  <= popcount8(qm[7:0]);
      de_s1  <= de;
      ctl_s1 <= ctl;
    end
  end

  // diff is N1-N0 of q_m[7:0]; 6-bit math keeps every intermediate in range.
  always_comb begin
    cnt_w    = {cnt[4], cnt};
    diff     = $signed({1'b0, n1_s1, 1'b0}) - 6'sd8;
    sym_next = tmds_ctl_token(ctl_s1);
    cnt_next = '0;
    if (de_s1) begin
      if ((cnt == 5'sd0) || (diff == 6'sd0)) begin
        sym_next = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
        cnt_next = qm_s1[8] ? (cnt_w + diff) : (cnt_w - diff);
      end else if (((cnt > 5'sd0) && (diff > 6'sd0)) ||
                   ((cnt < 5'sd0) && (diff < 6'sd0))) begin
        sym_next = {1'b1, qm_s1[8], ~qm_s1[7:0]};
        cnt_next = cnt_w - diff + (qm_s1[8] ? 6'sd2 : 6'sd0);
      end else begin
        sym_next = {1'b0, qm_s1[8], qm_s1[7:0]};
        cnt_next = cnt_w + diff - (qm_s1[8] ? 6'sd0 : 6'sd2);
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!nreset) begin
      symbol <= TMDS_CTL_00;
      cnt    <= '0;
    end else begin
      symbol <= sym_next;
      cnt    <= $signed(cnt_next[4:0]);
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// DVI TMDS encoder: registers the pixel-stage outputs and feeds three
// independent channel encoders; only channel 0 carries the syncs.
module tmds_encoder
  import video_pkg::*;
#(
  parameter bit SYNC_INVERT = 1'b0
) (
  input  logic        clk_pixel,
  input  logic        nreset,
  input  logic [23:0] rgb,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  output logic [9:0]  tmds_red,
  output logic [9:0]  tmds_grn,
  output logic [9:0]  tmds_blu
);

  logic [23:0]            rgb_q;
  logic [1:0]             ctl_q;
  logic                   de_q;
  logic [2:0][SYM_W-1:0]  sym;

  // Inversion happens before the register so a cleared register means C=00.
  always_ff @(posedge clk_pixel) begin
    if (!nreset) begin
      rgb_q <= '0;
      ctl_q <= '0;
      de_q  <= 1'b0;
    end else begin
      rgb_q <= rgb;
      ctl_q <= {vsync, hsync} ^ {2{SYNC_INVERT}};
      de_q  <= ~blank;
    end
  end

  tmds_channel u_blu (
    .clk_pixel (clk_pixel),
    .nreset    (nreset),
    .data      (rgb_q[7:0]),
    .ctl       (ctl_q),
    .de        (de_q),
    .symbol    (sym[CH_BLU])
  );

  tmds_channel u_grn (
    .clk_pixel (clk_pixel),
    .nreset    (nreset),
    .data      (rgb_q[15:8]),
    .ctl       (2'b00),
    .de        (de_q),
    .symbol    (sym[CH_GRN])
  );

  tmds_channel u_red (
    .clk_pixel (clk_pixel),
    .nreset    (nreset),
    .data      (rgb_q[23:16]),
    .ctl       (2'b00),
    .de        (de_q),
    .symbol    (sym[CH_RED])
  );

  assign tmds_blu = sym[CH_BLU];
  assign tmds_grn = sym[CH_GRN];
  assign tmds_red = sym[CH_RED];

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: behavioural DVI encoder model with a 2-cycle delay
// line, per-cycle symbol compare, decode and disparity-bound checks.
module tb_tmds_encoder;

  localparam bit SYNC_INV = 1'b0;

  logic        clk_pixel = 1'b0;
  logic        nreset = 1'b0;
  logic [23:0] rgb = '0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        blank = 1'b1;
  logic [9:0]  tmds_red;
  logic [9:0]  tmds_grn;
  logic [9:0]  tmds_blu;

  int checks = 0;
  int errors = 0;

  logic [29:0] exp_q[$];
  logic [24:0] dat_q[$];
  logic [9:0]  tok[4];
  logic        pipe_de[2];
  logic [23:0] pipe_rgb[2];
  logic [1:0]  pipe_ctl[2];
  int          m_cnt[3];
  int          run_disp[3];
  logic [29:0] last_exp;

  tmds_encoder #(.SYNC_INVERT(SYNC_INV)) dut (
    .clk_pixel (clk_pixel),
    .nreset    (nreset),
    .rgb       (rgb),
    .hsync     (hsync),
    .vsync     (vsync),
    .blank     (blank),
    .tmds_red  (tmds_red),
    .tmds_grn  (tmds_grn),
    .tmds_blu  (tmds_blu)
  );

  // clock
  always #5 clk_pixel = ~clk_pixel;

  function automatic int ones(input logic [9:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] o;
    d = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  function automatic logic [9:0] model_encode(input int ch, input logic de,
                                              input logic [7:0] d, input logic [1:0] c);
    logic [8:0] qm;
    logic [9:0] s;
    int n1, k1, k0;
    bit xn;
    if (!de) begin
      m_cnt[ch] = 0;
      return tok[c];
    end
    n1 = ones({2'b00, d});
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    k1 = ones({2'b00, qm[7:0]});
    k0 = 8 - k1;
    if (m_cnt[ch] == 0 || k1 == k0) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      m_cnt[ch] += qm[8] ? (k1 - k0) : (k0 - k1);
    end else if ((m_cnt[ch] > 0 && k1 > k0) || (m_cnt[ch] < 0 && k0 > k1)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      m_cnt[ch] += 2 * int'(qm[8]) + k0 - k1;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      m_cnt[ch] += k1 - k0 - 2 * int'(!qm[8]);
    end
    return s;
  endfunction

  // Model: reset clears the delay line and counters; otherwise emit the pixel
  // sampled two edges ago and shift in the current inputs.
  task automatic model_step();
    logic [29:0] e;
    logic [24:0] dd;
    if (!nreset) begin
      for (int i = 0; i < 2; i++) begin
        pipe_de[i] = 1'b0;
        pipe_rgb[i] = '0;
        pipe_ctl[i] = '0;
      end
      for (int c = 0; c < 3; c++) m_cnt[c] = 0;
      e = {tok[0], tok[0], tok[0]};
      dd = '0;
    end else begin
      e[9:0]   = model_encode(0, pipe_de[1], pipe_rgb[1][7:0], pipe_ctl[1]);
      e[19:10] = model_encode(1, pipe_de[1], pipe_rgb[1][15:8], 2'b00);
      e[29:20] = model_encode(2, pipe_de[1], pipe_rgb[1][23:16], 2'b00);
      dd = {pipe_de[1], pipe_rgb[1]};
      pipe_de[1]  = pipe_de[0];
      pipe_rgb[1] = pipe_rgb[0];
      pipe_ctl[1] = pipe_ctl[0];
      pipe_de[0]  = !blank;
      pipe_rgb[0] = rgb;
      pipe_ctl[0] = {vsync, hsync} ^ {2{SYNC_INV}};
    end
    exp_q.push_back(e);
    dat_q.push_back(dd);
  endtask

  // Scoreboard: one clock, model update, then compare 1 ns after the edge.
  task automatic tick();
    logic [29:0] e;
    logic [24:0] dd;
    logic [9:0]  act;
    logic [7:0]  dec;
    @(posedge clk_pixel);
    model_step();
    #1;
    e = exp_q.pop_front();
    dd = dat_q.pop_front();
    last_exp = e;
    for (int ch = 0; ch < 3; ch++) begin
      act = (ch == 0) ? tmds_blu : (ch == 1) ? tmds_grn : tmds_red;
      checks++;
      if (act !== e[ch*10 +: 10]) begin
        errors++;
        $display("FAIL sym ch%0d: got %h want %h at %0t", ch, act, e[ch*10 +: 10], $time);
      end
      if (dd[24]) begin
        dec = decode(act);
        checks++;
        if (dec !== dd[ch*8 +: 8]) begin
          errors++;
          $display("FAIL decode ch%0d: got %h want %h at %0t", ch, dec, dd[ch*8 +: 8], $time);
        end
        run_disp[ch] += 2 * ones(act) - 10;
        checks++;
        if (run_disp[ch] > 8 || run_disp[ch] < -8) begin
          errors++;
          $display("FAIL disparity ch%0d: got %0d want within +-8 at %0t", ch, run_disp[ch], $time);
        end
      end else begin
        run_disp[ch] = 0;
      end
    end
  endtask

  task automatic drive(input logic [23:0] r, input logic h, input logic v, input logic b);
    rgb = r;
    hsync = h;
    vsync = v;
    blank = b;
    tick();
  endtask

  task automatic check_lit(input string name, input logic [9:0] act, input logic [9:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [9:0] expv);
    check_lit({name, "_blu"}, tmds_blu, expv);
    check_lit({name, "_grn"}, tmds_grn, expv);
    check_lit({name, "_red"}, tmds_red, expv);
    check_lit({name, "_model"}, last_exp[9:0], expv);
  endtask

  initial begin
    int run_len;
    logic cur_blank;
    logic [1:0] c;
    logic [23:0] r;
    tok[0] = 10'h354;
    tok[1] = 10'h0AB;
    tok[2] = 10'h154;
    tok[3] = 10'h2AB;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      run_disp[i] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      pipe_de[i] = 1'b0;
      pipe_rgb[i] = '0;
      pipe_ctl[i] = '0;
    end

    // reset held with random inputs
    nreset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1'($urandom), 1'($urandom), 1'b0);
      check_all("reset", 10'h354);
    end
    nreset = 1'b1;
    drive($urandom, 1'b0, 1'b0, 1'b0);
    check_all("post_reset0", 10'h354);
    drive($urandom, 1'b0, 1'b0, 1'b0);
    check_all("post_reset1", 10'h354);

    // control tokens
    for (int k = 0; k < 4; k++) begin
      c = 2'(k);
      repeat (3) drive($urandom, c[0], c[1], 1'b1);
      check_lit("ctl_blu", tmds_blu, tok[k]);
      check_lit("ctl_model", last_exp[9:0], tok[k]);
      check_lit("ctl_grn", tmds_grn, 10'h354);
      check_lit("ctl_red", tmds_red, 10'h354);
    end

    // zero data run: cnt 0 -> -8 -> +2 -> -6
    repeat (3) drive(24'h0, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(24'h0, 1'b0, 1'b0, 1'b0);
    check_all("zero0", 10'h100);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    check_all("zero1", 10'h3FF);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    check_all("zero2", 10'h100);

    // single 0xFF pixel between blanking: alignment and cnt=0 start
    repeat (3) drive(24'h0, 1'b0, 1'b0, 1'b1);
    drive(24'hFFFFFF, 1'b0, 1'b0, 1'b0);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    check_all("ff_before", 10'h354);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    check_all("ff_pixel", 10'h200);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    check_all("ff_after", 10'h354);

    // blank toggling every cycle
    for (int i = 0; i < 40; i++)
      drive($urandom, 1'($urandom), 1'($urandom), 1'(i % 2));

    // random sweep with random blank runs and rare mid-frame resets
    run_len = 0;
    cur_blank = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (run_len == 0) begin
        cur_blank = ~cur_blank;
        run_len = $urandom_range(1, 24);
      end
      run_len--;
      case ($urandom_range(0, 7))
        0:       r = 24'h000000;
        1:       r = 24'hFFFFFF;
        default: r = $urandom;
      endcase
      nreset = ($urandom_range(0, 999) != 0);
      drive(r, 1'($urandom), 1'($urandom), cur_blank);
    end
    nreset = 1'b1;
    repeat (3) drive(24'h0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
